wb_mem_slave: RTL and testbench
===============================

# wb_mem_slave

Wishbone classic responder: a word-organised, byte-lane-writable memory that answers the load/store requests issued by the execute/memory stage's Wishbone master. It sits on the data bus opposite `exm` and stands in for data RAM in simulation and small FPGA builds. A programmable number of wait states exercises the master's stall handling.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, 0: extra cycles inserted between request capture and `wb_ack_o`; range 0–15.
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `wb_adr_i`  in  32  byte address; bits [1:0] ignored.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data; valid only while `wb_ack_o`=1.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_sel_i`  in  4  byte-lane enables; bit i covers bits [8i+7:8i].
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  bus cycle in progress.
- `wb_ack_o`  out  1  single-cycle acknowledge.

## Operation
- Word index = `wb_adr_i[log2(DEPTH)+1:2]`. The request is in range when `wb_adr_i` < 4·DEPTH.
- FSM states are IDLE, WAIT and ACK.
  - IDLE: if `wb_cyc_i`&`wb_stb_i`, capture adr/dat/we/sel.
    - With `WAIT_CYCLES`=0, go to ACK.
    - Otherwise load the wait counter with `WAIT_CYCLES`-1 and go to WAIT.
  - WAIT: if `wb_cyc_i`=0, abort to IDLE with no write and no ack. Else if counter = 0, go to ACK. Else decrement.
  - ACK: `wb_ack_o`=1 for exactly this cycle, then unconditionally go to IDLE.
- Writes:
  - Committed on the edge entering ACK, using the captured values.
  - Only lanes with `sel`=1 change.
  - `sel`=4'b0000 changes nothing but is still acked.
- Reads:
  - `wb_dat_o` is registered on the edge entering ACK and returns the full word regardless of `sel`.
  - Lane selection and extension are the master's job.
  - Outside ACK, `wb_dat_o` is driven to 0.
- Out-of-range requests:
  - Handled with the same timing.
  - Writes are dropped.
  - Reads return 32'h0000_0000.
- Captured values are used for the whole transaction. Input changes after capture are ignored.
- `wb_cyc_i` falling during ACK has no effect: the write is already done and the ack still pulses.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Request sampled at edge N → `wb_ack_o` high during cycle N+1+`WAIT_CYCLES`.
- Back-to-back requests:
  - After an ack the slave is in IDLE. A strobe still high in the cycle after ack is a new request.
  - Maximum throughput is one access per 2+`WAIT_CYCLES` cycles.
- Read-after-write to the same word: the read sees the new data, because the write completes before the read is captured.
- Asserting `rst_ni`=0 mid-transaction:
  - Ack and data clear immediately (asynchronous).
  - A write not yet committed is lost.
  - A write already committed stays in memory.
- `wb_ack_o` is never asserted while in IDLE or WAIT, and never for two consecutive cycles.

## Test plan
1. `WAIT_CYCLES`=0:
   - Write adr 0x10, data 0xDEADBEEF, sel 4'hF → ack exactly 1 cycle after capture.
   - Read adr 0x10 → ack after 1 cycle, `wb_dat_o`=0xDEADBEEF.
2. Byte lanes:
   - Preload 0x11223344 at adr 0x20.
   - Write 0xAABBCCDD with sel 4'b0101 → reading adr 0x20 returns 0x11BB33DD.
   - Write with sel 0 → ack, word unchanged.
3. `WAIT_CYCLES`=3:
   - Read → ack in cycle N+4 only; `wb_ack_o` and `wb_dat_o` stay 0 in cycles N+1..N+3.
   - Hold stb high continuously → acks spaced exactly 5 cycles apart.
4. Abort:
   - With `WAIT_CYCLES`=3, write 0xCAFEF00D to adr 0x30 and drop `wb_cyc_i` in the 2nd wait cycle → no ack; word at 0x30 unchanged.
5. Out of range:
   - With `DEPTH`=1024, write 0x12345678 to adr 0x1000 → acked; word 0 unchanged.
   - Read adr 0x1000 → 0x00000000.
6. Reset:
   - Pull `rst_ni` low during WAIT → `wb_ack_o`=0 and `wb_dat_o`=0 at once; no ack after release.
   - A subsequent read of a previously written word returns its old value.

Source files
------------

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone classic data-memory responder with byte-lane writes
// and a fixed number of wait states between request capture and acknowledge.
// Memory contents are deliberately left unreset; only control state and the
// bus outputs are cleared by rst_ni.
module wb_mem_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o
);

    localparam int unsigned AW        = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;
    // Byte-address limit kept 34 bits wide so 4*DEPTH cannot overflow.
    localparam logic [33:0] ADR_LIMIT = 34'(DEPTH) * 34'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic [3:0]  r_sel;

    logic        w_req;
    logic        w_capture;
    logic        w_commit;

    logic [31:0] w_adr;
    logic [31:0] w_dat;
    logic        w_we;
    logic [3:0]  w_sel;
    logic        w_in_range;
    logic [AW-1:0] w_idx;

    logic        r_ack;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    assign w_req = wb_cyc_i & wb_stb_i;

    // Next-state, wait counter and capture/commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 32'd0) begin
                        w_state_nxt = ST_ACK;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    // Master abandoned the cycle: no write, no ack.
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction operands: live bus when committing straight from IDLE,
    // otherwise the values captured at request time.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_adr = wb_adr_i;
            w_dat = wb_dat_i;
            w_we  = wb_we_i;
            w_sel = wb_sel_i;
        end else begin
            w_adr = r_adr;
            w_dat = r_dat;
            w_we  = r_we;
            w_sel = r_sel;
        end
    end

    assign w_in_range = ({2'b00, w_adr} < ADR_LIMIT);
    assign w_idx      = w_adr[AW+1:2];

    // FSM state and wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request capture; later bus changes within the transaction are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_adr <= 32'h0;
            r_dat <= 32'h0;
            r_we  <= 1'b0;
            r_sel <= 4'h0;
        end else if (w_capture) begin
            r_adr <= wb_adr_i;
            r_dat <= wb_dat_i;
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
        end
    end

    // Byte-lane write commit on the edge entering ACK; out-of-range writes drop.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_we && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
                end
            end
        end
    end

    // Registered acknowledge and read data, both valid only in the ACK cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ack <= w_commit;
            if (w_commit && !w_we && w_in_range) begin
                r_rdata <= r_mem[w_idx];
            end else begin
                r_rdata <= 32'h0;
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_rdata;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: one instance with no wait states and
// one with three, driven through a scoreboard of expected read results.
module tb_wb_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic        stb  [2];
    logic        cyc  [2];
    logic        ack  [2];

    wb_mem_slave #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
        .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]),
        .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0])
    );

    wb_mem_slave #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
        .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]),
        .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q [$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   lat [2] = '{1, 4};

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        cyc[d]  = 1'b0;
        stb[d]  = 1'b0;
        we[d]   = 1'b0;
        adr[d]  = 32'h0;
        wdat[d] = 32'h0;
        sel[d]  = 4'h0;
    endtask

    task automatic drive(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
        cyc[d]  = 1'b1;
        stb[d]  = 1'b1;
        we[d]   = w;
        adr[d]  = a;
        wdat[d] = wd;
        sel[d]  = s;
    endtask

    // One complete transaction; optionally scrambles the bus after capture.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input logic [31:0] exp_rd, input bit mutate);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(negedge clk);
        drive(d, w, a, wd, s);
        e.we   = w;
        e.data = exp_rd;
        sb_q.push_back(e);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (mutate && k == 1) begin
                adr[d]  = ~a;
                wdat[d] = ~wd;
                sel[d]  = 4'hF;
                we[d]   = ~w;
            end
            if (ack[d]) begin
                got = 1'b1;
                chk("ack_latency", 32'(k), 32'(lat[d]));
                e = sb_q.pop_front();
                if (!e.we) begin
                    chk("read_data", rdat[d], e.data);
                end
                idle_bus(d);
            end else if (!w) begin
                chk("dat_quiet", rdat[d], 32'h0);
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'h0, 32'h1);
            e = sb_q.pop_front();
            idle_bus(d);
        end
        @(negedge clk);
        chk("ack_single", 32'(ack[d]), 32'h0);
    endtask

    // Counts acks on one instance over n cycles.
    task automatic count_acks(input int d, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ack[d]) cnt++;
        end
    endtask

    initial begin
        exp_t e;
        int   n_ack;
        int   next_pos;

        rst_n = 1'b0;
        idle_bus(0);
        idle_bus(1);
        repeat (3) @(negedge clk);
        chk("rst_ack0", 32'(ack[0]), 32'h0);
        chk("rst_dat0", rdat[0], 32'h0);
        chk("rst_ack3", 32'(ack[1]), 32'h0);
        chk("rst_dat3", rdat[1], 32'h0);
        rst_n = 1'b1;

        // Zero wait states: basic write/read.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        // Byte lanes; reads return the full word whatever sel says.
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'b0001, 32'h11BB33DD, 1'b0);
        xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);

        // Three wait states; write with bus scrambled after capture.
        xfer(1, 1'b1, 32'h10, 32'h5A5A1234, 4'hF, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h5A5A1234, 1'b0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5A5A1234, 1'b1);

        // Strobe held: acks at cycles 4, 9, 14.
        @(negedge clk);
        drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            e.we   = 1'b0;
            e.data = 32'h5A5A1234;
            sb_q.push_back(e);
        end
        n_ack    = 0;
        next_pos = 4;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ack[1]) begin
                chk("b2b_pos", 32'(k), 32'(next_pos));
                next_pos += 5;
                n_ack++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("b2b_data", rdat[1], e.data);
                end
            end
            if (k == 14) idle_bus(1);
        end
        chk("b2b_count", 32'(n_ack), 32'd3);
        sb_q.delete();
        @(negedge clk);
        chk("b2b_ack_end", 32'(ack[1]), 32'h0);

        // Abort: drop cyc in the second wait cycle.
        xfer(1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        @(negedge clk);
        idle_bus(1);
        count_acks(1, 8, n_ack);
        chk("abort_noack", 32'(n_ack), 32'd0);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, 32'h55AA55AA, 1'b0);

        // Out of range with DEPTH=1024.
        xfer(0, 1'b1, 32'h0, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0F0F0F0F, 1'b0);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b0);

        // Reset during WAIT loses the pending write.
        xfer(1, 1'b1, 32'h40, 32'h01020304, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        drive(1, 1'b1, 32'h40, 32'h99999999, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ack", 32'(ack[1]), 32'h0);
        chk("rst_wait_dat", rdat[1], 32'h0);
        idle_bus(1);
        @(negedge clk);
        rst_n = 1'b1;
        count_acks(1, 8, n_ack);
        chk("rst_wait_noack", 32'(n_ack), 32'd0);

        // Reset during ACK clears ack and data immediately.
        @(negedge clk);
        drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
        repeat (4) @(negedge clk);
        chk("pre_rst_ack", 32'(ack[1]), 32'h1);
        chk("pre_rst_dat", rdat[1], 32'h5A5A1234);
        rst_n = 1'b0;
        #1;
        chk("rst_ack_ack", 32'(ack[1]), 32'h0);
        chk("rst_ack_dat", rdat[1], 32'h0);
        idle_bus(1);
        @(negedge clk);
        rst_n = 1'b1;
        count_acks(1, 8, n_ack);
        chk("rst_ack_noack", 32'(n_ack), 32'd0);

        // Committed data survives reset; lost write never landed.
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h01020304, 1'b0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h5A5A1234, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
